// File: rtl/udp_fifo_tx_reader.sv
// Read side of the UDP loopback payload FIFO: drains one posted payload
// through a 2-entry skid buffer and frames it as a valid/ready byte stream.
module udp_fifo_tx_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_LEN    = 1472,
    parameter int MIN_GAP    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  len_valid,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  len_drop,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_first,
    output logic                  tx_last,
    output logic [LEN_WIDTH-1:0]  tx_byte_num,
    output logic                  busy,
    output logic                  underrun
);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
    localparam logic [7:0]           GAP_INIT  = 8'(MIN_GAP);

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rdRemain_q, rdRemain_d;
    logic [LEN_WIDTH-1:0]  txRemain_q, txRemain_d;
    logic [LEN_WIDTH-1:0]  byteNum_q, byteNum_d;
    logic                  underrun_q, underrun_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;
    logic                  firstPending_q, firstPending_d;
    logic [7:0]            gapCnt_q, gapCnt_d;
    logic                  lenDrop_q, lenDrop_d;

    logic                  txValid;
    logic                  pop;
    logic                  lenOk;
    logic                  rdEn;

    // State and datapath registers; reset abandons any packet in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rdRemain_q     <= '0;
            txRemain_q     <= '0;
            byteNum_q      <= '0;
            underrun_q     <= 1'b0;
            inflight_q     <= 1'b0;
            head_q         <= '0;
            tail_q         <= '0;
            occ_q          <= 2'd0;
            firstPending_q <= 1'b0;
            gapCnt_q       <= 8'd0;
            lenDrop_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            rdRemain_q     <= rdRemain_d;
            txRemain_q     <= txRemain_d;
            byteNum_q      <= byteNum_d;
            underrun_q     <= underrun_d;
            inflight_q     <= inflight_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            occ_q          <= occ_d;
            firstPending_q <= firstPending_d;
            gapCnt_q       <= gapCnt_d;
            lenDrop_q      <= lenDrop_d;
        end
    end

    // Next-state logic: length acceptance, read issue, skid buffer and framing.
    always_comb begin
        state_d        = state_q;
        rdRemain_d     = rdRemain_q;
        txRemain_d     = txRemain_q;
        byteNum_d      = byteNum_q;
        underrun_d     = underrun_q;
        head_d         = head_q;
        tail_d         = tail_q;
        occ_d          = occ_q;
        firstPending_d = firstPending_q;
        gapCnt_d       = gapCnt_q;
        lenDrop_d      = 1'b0;
        rdEn           = 1'b0;

        txValid = (state_q == STREAM) && (occ_q != 2'd0);
        pop     = txValid && tx_ready;
        lenOk   = (len != '0) && (len <= MAX_LEN_L);

        case (state_q)
            IDLE: begin
                if (len_valid) begin
                    if (lenOk) begin
                        state_d        = STREAM;
                        rdRemain_d     = len;
                        txRemain_d     = len;
                        byteNum_d      = len;
                        underrun_d     = 1'b0;
                        firstPending_d = 1'b1;
                    end else if (len > MAX_LEN_L) begin
                        lenDrop_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (len_valid) begin
                    lenDrop_d = 1'b1;
                end
                if (fifo_empty && (rdRemain_q != '0)) begin
                    underrun_d = 1'b1;
                end
                if (!fifo_empty && (rdRemain_q != '0) &&
                    (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}))) begin
                    rdEn       = 1'b1;
                    rdRemain_d = rdRemain_q - 1'b1;
                end
                if (pop) begin
                    firstPending_d = 1'b0;
                    if (txRemain_q != '0) begin
                        txRemain_d = txRemain_q - 1'b1;
                    end
                    if (txRemain_q == LEN_WIDTH'(1)) begin
                        state_d  = GAP;
                        gapCnt_d = GAP_INIT;
                    end
                end
            end
            GAP: begin
                if (len_valid) begin
                    lenDrop_d = 1'b1;
                end
                if (gapCnt_q <= 8'd1) begin
                    state_d  = IDLE;
                    gapCnt_d = 8'd0;
                end else begin
                    gapCnt_d = gapCnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        inflight_d = rdEn;

        case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_rd_data;
                end else begin
                    tail_d = fifo_rd_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = fifo_rd_data;
                end else begin
                    head_d = tail_q;
                    tail_d = fifo_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Output drive; first/last qualify only a presented byte.
    always_comb begin
        fifo_rd_en  = rdEn;
        tx_valid    = txValid;
        tx_data     = head_q;
        tx_first    = txValid && firstPending_q;
        tx_last     = txValid && (txRemain_q == LEN_WIDTH'(1));
        tx_byte_num = byteNum_q;
        busy        = (state_q != IDLE);
        underrun    = underrun_q;
        len_drop    = lenDrop_q;
    end

endmodule

// File: tb/tb_udp_fifo_tx_reader.sv
// Testbench for udp_fifo_tx_reader: a queue-based FIFO model feeds the DUT,
// and a packet-level reference model is compared against the stream each cycle.
module tb_udp_fifo_tx_reader;

    localparam int DW   = 8;
    localparam int LW   = 16;
    localparam int MAXL = 1472;
    localparam int GAPN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          len_valid = 1'b0;
    logic [LW-1:0] len = '0;
    logic          len_drop;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_first;
    logic          tx_last;
    logic [LW-1:0] tx_byte_num;
    logic          busy;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    udp_fifo_tx_reader #(
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW),
        .MAX_LEN   (MAXL),
        .MIN_GAP   (GAPN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .len_valid   (len_valid),
        .len         (len),
        .len_drop    (len_drop),
        .fifo_rd_en  (fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_first    (tx_first),
        .tx_last     (tx_last),
        .tx_byte_num (tx_byte_num),
        .busy        (busy),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // FIFO contents, the expected byte order, and writes waiting for the next edge.
    logic [7:0] fifoQ[$];
    logic [7:0] refQ[$];
    logic [7:0] wrPend[$];
    logic [7:0] popLog[$];
    logic       rdEnSeen = 1'b0;
    logic       rstQ = 1'b0;

    // Packet-level reference model state.
    bit          mActive = 1'b0;
    int          mGap = 0;
    bit          mUnderrun = 1'b0;
    bit          mDropNext = 1'b0;
    int          mLen = 0;
    int          mReads = 0;
    int          mPops = 0;
    int          mTxCount = 0;
    bit          holdPrev = 1'b0;
    logic [7:0]  holdData = '0;
    bit          prevBusy = 1'b0;
    int          cyc = 0;
    int          acceptCyc = 0;
    int          firstValidCyc = -1;
    int          firstPopCyc = 0;
    int          lastPopCyc = 0;
    int          busyFallCyc = 0;
    int          rdEnTotal = 0;
    logic [15:0] firstByteNum = '0;

    int readyMode = 0;
    int stepCount = 0;

    function automatic void checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endfunction

    // Registered-read FIFO: a read seen in a cycle returns data after the next edge.
    always @(posedge clk) begin : fifoModel
        logic [7:0] b;
        if (rdEnSeen && (fifoQ.size() > 0)) begin
            fifo_rd_data <= fifoQ.pop_front();
        end
        while (wrPend.size() > 0) begin
            b = wrPend.pop_front();
            fifoQ.push_back(b);
            refQ.push_back(b);
        end
        fifo_empty <= (fifoQ.size() == 0);
    end

    always @(posedge clk) rstQ <= rst;

    // Compare the DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin : compareProc
        bit idleNow;
        bit popNow;
        logic [31:0] expData;
        cyc++;
        rdEnSeen = fifo_rd_en;
        if (rst) begin
            mActive   = 1'b0;
            mGap      = 0;
            mUnderrun = 1'b0;
            mDropNext = 1'b0;
            holdPrev  = 1'b0;
            prevBusy  = 1'b0;
            popLog.delete();
        end else begin
            if (rstQ) begin
                checkOutput("resetFlags",
                            {25'd0, tx_valid, fifo_rd_en, busy, underrun, len_drop, tx_first, tx_last},
                            32'd0);
                checkOutput("resetData", 32'(tx_data), 32'd0);
                checkOutput("resetByteNum", 32'(tx_byte_num), 32'd0);
            end else begin
                checkOutput("busy", 32'(busy), 32'(mActive || (mGap > 0)));
                checkOutput("lenDrop", 32'(len_drop), 32'(mDropNext));
                checkOutput("underrun", 32'(underrun), 32'(mUnderrun));
                if (!mActive) begin
                    checkOutput("idleValid", 32'(tx_valid), 32'd0);
                    checkOutput("idleRdEn", 32'(fifo_rd_en), 32'd0);
                end
                if (fifo_rd_en) begin
                    checkOutput("rdWhileEmpty", 32'(fifo_empty), 32'd0);
                end
                if (holdPrev) begin
                    checkOutput("holdValid", 32'(tx_valid), 32'd1);
                    checkOutput("holdData", 32'(tx_data), 32'(holdData));
                end
                if (tx_valid && mActive) begin
                    expData = (refQ.size() > 0) ? 32'(refQ[0]) : 32'h100;
                    checkOutput("txData", 32'(tx_data), expData);
                    checkOutput("txFirst", 32'(tx_first), 32'(mTxCount == 0));
                    checkOutput("txLast", 32'(tx_last), 32'(mTxCount == mLen - 1));
                    checkOutput("byteNum", 32'(tx_byte_num), 32'(mLen));
                end
            end
            if (prevBusy && !busy) busyFallCyc = cyc;
            prevBusy = busy;

            idleNow = !mActive && (mGap == 0);
            popNow  = tx_valid && tx_ready;
            if (tx_valid && mActive && (firstValidCyc < 0)) firstValidCyc = cyc;
            if (mActive && fifo_empty && (mReads < mLen)) mUnderrun = 1'b1;
            if (fifo_rd_en) begin
                rdEnTotal++;
                mReads++;
            end
            if (mActive && fifo_rd_en) checkOutput("readBudget", 32'(mReads <= mLen), 32'd1);
            if (mGap > 0) mGap--;
            if (popNow && mActive) begin
                if (mTxCount == 0) begin
                    firstPopCyc  = cyc;
                    firstByteNum = tx_byte_num;
                end
                popLog.push_back(tx_data);
                if (refQ.size() > 0) void'(refQ.pop_front());
                mPops++;
                mTxCount++;
            end
            if (mActive) checkOutput("occupancy", 32'((mReads - mPops) <= 2), 32'd1);
            if (popNow && mActive && (mTxCount == mLen)) begin
                checkOutput("readsPerPacket", 32'(mReads), 32'(mLen));
                mActive    = 1'b0;
                mGap       = GAPN;
                lastPopCyc = cyc;
            end
            holdPrev  = tx_valid && !tx_ready;
            holdData  = tx_data;
            mDropNext = len_valid && (!idleNow || (int'(len) > MAXL));
            if (len_valid && idleNow && (len != '0) && (int'(len) <= MAXL)) begin
                mActive       = 1'b1;
                mLen          = int'(len);
                mReads        = 0;
                mPops         = 0;
                mTxCount      = 0;
                mUnderrun     = 1'b0;
                acceptCyc     = cyc;
                firstValidCyc = -1;
                popLog.delete();
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
        stepCount++;
        case (readyMode)
            0: tx_ready = 1'b1;
            1: tx_ready = ((stepCount % 4) == 0) || ((stepCount % 4) == 3);
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic applyStimulus(input int l);
        len       = LW'(l);
        len_valid = 1'b1;
        stepCycle();
        len_valid = 1'b0;
    endtask

    task automatic fifoWrite(input logic [7:0] b);
        wrPend.push_back(b);
    endtask

    task automatic waitDone(input int maxc);
        int n = 0;
        while ((mActive || (mGap > 0)) && (n < maxc)) begin
            stepCycle();
            n++;
        end
        checkOutput("waitDone", 32'(n < maxc), 32'd1);
    endtask

    initial begin
        int l, k, saveLast, saveRd;
        logic [7:0] payload[$];

        rst = 1'b1;
        readyMode = 0;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();

        // Test 1: 8 descending bytes at full rate.
        for (int i = 0; i < 8; i++) fifoWrite(8'(8'hFF - i));
        stepCycle();
        stepCycle();
        applyStimulus(8);
        waitDone(100);
        stepCycle();
        checkOutput("t1Latency", 32'(firstValidCyc - acceptCyc), 32'd3);
        checkOutput("t1Count", 32'(popLog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < popLog.size()) checkOutput("t1Byte", 32'(popLog[i]), 32'(8'hFF - i));
        end
        checkOutput("t1Consecutive", 32'(lastPopCyc - firstPopCyc), 32'd7);
        checkOutput("t1Reads", 32'(mReads), 32'd8);
        checkOutput("t1ByteNum", 32'(firstByteNum), 32'd8);
        checkOutput("t1BusyFall", 32'(busyFallCyc - lastPopCyc), 32'(GAPN + 1));

        // Test 2: maximum packet with a 1,0,0,1 ready pattern.
        readyMode = 1;
        payload.delete();
        for (int i = 0; i < MAXL; i++) begin
            payload.push_back(8'($urandom));
            fifoWrite(payload[i]);
        end
        stepCycle();
        stepCycle();
        applyStimulus(MAXL);
        waitDone(8000);
        checkOutput("t2Count", 32'(popLog.size()), 32'(MAXL));
        for (int i = 0; i < MAXL; i++) begin
            if ((i < popLog.size()) && (popLog[i] !== payload[i])) begin
                checkOutput("t2Byte", 32'(popLog[i]), 32'(payload[i]));
            end
        end

        // Test 3: oversize, zero length, and a length posted mid-packet.
        readyMode = 0;
        saveRd = rdEnTotal;
        applyStimulus(MAXL + 1);
        checkOutput("t3DropLong", 32'(len_drop), 32'd1);
        for (int i = 0; i < 4; i++) stepCycle();
        checkOutput("t3NoRead", 32'(rdEnTotal), 32'(saveRd));
        applyStimulus(0);
        checkOutput("t3ZeroNoDrop", 32'(len_drop), 32'd0);
        checkOutput("t3ZeroIdle", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) fifoWrite(8'(8'h30 + i));
        stepCycle();
        stepCycle();
        applyStimulus(10);
        stepCycle();
        stepCycle();
        applyStimulus(4);
        checkOutput("t3DropBusy", 32'(len_drop), 32'd1);
        waitDone(100);
        checkOutput("t3Count", 32'(popLog.size()), 32'd10);
        if (popLog.size() == 10) checkOutput("t3LastByte", 32'(popLog[9]), 32'h39);

        // Test 4: underrun with the tail of the payload arriving late.
        for (int i = 0; i < 3; i++) fifoWrite(8'(8'hA0 + i));
        stepCycle();
        stepCycle();
        applyStimulus(6);
        for (int i = 0; i < 20; i++) stepCycle();
        checkOutput("t4Underrun", 32'(underrun), 32'd1);
        checkOutput("t4Stalled", 32'(popLog.size()), 32'd3);
        for (int i = 3; i < 6; i++) fifoWrite(8'(8'hA0 + i));
        waitDone(100);
        checkOutput("t4Count", 32'(popLog.size()), 32'd6);
        if (popLog.size() == 6) checkOutput("t4LastByte", 32'(popLog[5]), 32'hA5);
        checkOutput("t4Sticky", 32'(underrun), 32'd1);

        // Test 6: back-to-back packets at the earliest accept point.
        for (int i = 0; i < 8; i++) fifoWrite(8'(8'h50 + i));
        stepCycle();
        stepCycle();
        applyStimulus(4);
        checkOutput("t6UnderrunClear", 32'(underrun), 32'd0);
        waitDone(100);
        saveLast = lastPopCyc;
        applyStimulus(4);
        checkOutput("t6Accepted", 32'(busy), 32'd1);
        checkOutput("t6GapSpacing", 32'(acceptCyc - saveLast), 32'(GAPN + 1));
        waitDone(100);
        checkOutput("t6FirstLatency", 32'(firstValidCyc - acceptCyc), 32'd3);
        if (popLog.size() == 4) checkOutput("t6FirstByte", 32'(popLog[0]), 32'h54);

        // Randomized packets with random ready, late data and stray lengths.
        readyMode = 2;
        for (int p = 0; p < 10; p++) begin
            l = $urandom_range(1, 40);
            k = $urandom_range(0, l);
            for (int i = 0; i < k; i++) fifoWrite(8'($urandom));
            stepCycle();
            stepCycle();
            applyStimulus(l);
            stepCycle();
            if (mActive && ($urandom_range(0, 1) == 1)) applyStimulus($urandom_range(0, 2000));
            for (int i = 0; i < int'($urandom_range(0, 8)); i++) stepCycle();
            for (int i = k; i < l; i++) fifoWrite(8'($urandom));
            waitDone(2000);
            checkOutput("rndCount", 32'(popLog.size()), 32'(l));
        end

        // Test 5: reset in the middle of a long packet.
        readyMode = 0;
        for (int i = 0; i < 500; i++) fifoWrite(8'($urandom));
        stepCycle();
        stepCycle();
        applyStimulus(500);
        k = 0;
        while ((mPops < 100) && (k < 1000)) begin
            stepCycle();
            k++;
        end
        checkOutput("t5Reached", 32'(k < 1000), 32'd1);
        rst = 1'b1;
        fifoQ.delete();
        refQ.delete();
        wrPend.delete();
        for (int i = 0; i < 5; i++) fifoWrite(8'(8'hC0 + i));
        stepCycle();
        rst = 1'b0;
        checkOutput("t5Valid", 32'(tx_valid), 32'd0);
        checkOutput("t5RdEn", 32'(fifo_rd_en), 32'd0);
        checkOutput("t5Busy", 32'(busy), 32'd0);
        applyStimulus(5);
        checkOutput("t5Reaccept", 32'(busy), 32'd1);
        waitDone(100);
        checkOutput("t5Count", 32'(popLog.size()), 32'd5);
        if (popLog.size() == 5) checkOutput("t5FirstByte", 32'(popLog[0]), 32'hC0);

        stepCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
